clk_rst_manager: RTL
====================

Name: clk_rst_manager

Overview:
Parametrised clock-enable and reset manager for board top levels. It supersedes the hard-coded pattern of reset counter, PLL-lock gating and divide-by-2 toggle that each top level currently writes by hand. It waits for a filtered, synchronised PLL lock, then stretches reset for a set number of cycles. After release it generates NUM_CH runtime-programmable clock-enable strobes and divided square waves, plus a heartbeat. It re-enters reset automatically on lock loss or on a soft-reset request.

Parameters:
RESET_CYCLES, 65536, cycles of continuous lock in STRETCH before reset release (>=2)
LOCK_GLITCH, 4, consecutive synchronised lock-low cycles that declare lock loss (>=1)
NUM_CH, 2, number of divider channels (>=1)
DIV_W, 8, divisor width per channel
HEARTBEAT_BIT, 23, bit of the free-running counter driven to heartbeat_out

Ports:
clk_ref_in  input  1  reference clock; all logic in this single domain
reset_in  input  1  asynchronous, active-high reset
pll_lock_in  input  1  PLL lock, asynchronous; synchronised internally by a 2-FF synchroniser
soft_reset_in  input  1  synchronous one-cycle request to re-stretch reset
div_in  input  NUM_CH*DIV_W  per-channel divisor D; channel i uses bits [i*DIV_W +: DIV_W]
reset_out  output  1  active-high system reset, registered
resetn_out  output  1  inverse of reset_out, registered
state_out  output  2  FSM state: 0 WAIT_LOCK, 1 STRETCH, 2 RUN
clk_en_out  output  NUM_CH  one-cycle enable strobe per channel
clk_div_out  output  NUM_CH  square wave per channel; toggles on each strobe
heartbeat_out  output  1  free-running counter bit HEARTBEAT_BIT
lock_loss_cnt_out  output  8  saturating lock-loss count (see Optional Feature)

Behaviour:
- reset_in values: state WAIT_LOCK, reset_out=1, resetn_out=0, clk_en_out=0, clk_div_out=0, heartbeat counter=0, synchroniser=0, lock_loss_cnt=0.
- lock_s: output of the 2-FF synchroniser.
- lock_lost: set when the lock-low counter reaches LOCK_GLITCH. The counter counts consecutive lock_s=0 cycles and clears when lock_s=1.
- WAIT_LOCK -> STRETCH when lock_s=1. The stretch counter is cleared on entry.
- STRETCH:
  - counter increments each cycle;
  - lock_lost -> WAIT_LOCK;
  - counter == RESET_CYCLES-1 -> RUN.
- RUN:
  - lock_lost -> WAIT_LOCK;
  - soft_reset_in -> STRETCH with the counter cleared.
- soft_reset_in in STRETCH restarts the counter. soft_reset_in is ignored in WAIT_LOCK.
- If soft_reset_in and lock_lost occur in the same cycle, lock_lost wins.
- reset_out is registered alongside state: it equals 0 exactly when state=RUN and updates on the same edge as state.
- Latency: lock rising and stable at edge 1 gives reset_out=0 after edge RESET_CYCLES+3.
- Dividers are held cleared (counter 0, outputs 0) whenever state != RUN. In RUN each channel:
  - D_eff = max(D,1);
  - D is latched on RUN entry and at each wrap, so a mid-period change takes effect in the next period;
  - the counter increments; at D_eff-1 it wraps to 0, clk_en_out pulses high for 1 cycle and clk_div_out toggles;
  - first strobe occurs D_eff cycles after reset_out falls;
  - D=0 or D=1 gives a strobe every cycle and clk_div_out at f/2.
- Heartbeat counter runs freely regardless of lock and wraps naturally; only reset_in clears it.
- reset_in asserted at any time, including mid-STRETCH or RUN, forces the reset values immediately (asynchronously).

Optional Feature:
LOCK_LOSS_CNT_EN:
- Defined: lock_loss_cnt_out counts RUN->WAIT_LOCK transitions and saturates at 255. Only reset_in clears it.
- Undefined: the port is tied to 0 and no counter logic is built.

Test Plan:
1. RESET_CYCLES=16; release reset_in, hold pll_lock_in=1 from edge 1 -> state 0->1 at edge 3, state 2 and reset_out=0 after edge 19, resetn_out=1.
2. LOCK_GLITCH=4, in RUN; drop lock for 3 cycles -> stays RUN. Drop lock for 4 cycles -> WAIT_LOCK, reset_out=1, dividers cleared, lock_loss_cnt_out=1 (with macro) or 0 (without).
3. div_in ch0=3, ch1=0 -> ch0 strobes every 3rd cycle, first 3 cycles after release, clk_div_out period 6. ch1 strobes every cycle, clk_div_out period 2.
4. ch0 D changed 3->5 one cycle after a wrap -> the current period still ends after 3 cycles, subsequent strobes every 5.
5. soft_reset_in pulse in RUN -> next edge state=STRETCH, reset_out=1, held for 16 cycles, then RUN. Pulse together with lock_lost -> WAIT_LOCK.
6. Assert reset_in asynchronously mid-STRETCH, between clock edges -> all outputs take their reset values without waiting for a clock edge. HEARTBEAT_BIT=3 -> heartbeat_out toggles every 8 cycles after release, independent of lock.

Source files
------------

// File: rtl/clk_rst_manager.sv
// Lock-qualified reset stretcher with runtime-programmable clock-enable dividers and heartbeat.
// Define LOCK_LOSS_CNT_EN to build the saturating RUN->WAIT_LOCK loss counter.
module clk_rst_manager #(
    parameter int unsigned RESET_CYCLES  = 65536,
    parameter int unsigned LOCK_GLITCH   = 4,
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned DIV_W         = 8,
    parameter int unsigned HEARTBEAT_BIT = 23
) (
    input  logic                    clk_ref_in,
    input  logic                    reset_in,
    input  logic                    pll_lock_in,
    input  logic                    soft_reset_in,
    input  logic [NUM_CH*DIV_W-1:0] div_in,
    output logic                    reset_out,
    output logic                    resetn_out,
    output logic [1:0]              state_out,
    output logic [NUM_CH-1:0]       clk_en_out,
    output logic [NUM_CH-1:0]       clk_div_out,
    output logic                    heartbeat_out,
    output logic [7:0]              lock_loss_cnt_out
);

    localparam int unsigned SW  = $clog2(RESET_CYCLES);
    localparam int unsigned GW  = $clog2(LOCK_GLITCH + 1);
    localparam int unsigned HbW = HEARTBEAT_BIT + 1;

    localparam logic [SW-1:0] StretchLast = SW'(RESET_CYCLES - 1);
    localparam logic [GW-1:0] GlitchLimit = GW'(LOCK_GLITCH);

    localparam logic [1:0] StWaitLock = 2'd0;
    localparam logic [1:0] StStretch  = 2'd1;
    localparam logic [1:0] StRun      = 2'd2;

    logic [1:0]       r_sync;
    logic             w_lock_s;
    logic [GW-1:0]    r_low_cnt;
    logic             w_lock_lost;
    logic [1:0]       r_state;
    logic [1:0]       w_state_d;
    logic [SW-1:0]    r_stretch;
    logic [SW-1:0]    w_stretch_d;
    logic             r_reset;
    logic             r_resetn;
    logic [HbW-1:0]   r_hb;
    logic             w_run_hold;
    logic [DIV_W-1:0] r_div_cnt [NUM_CH];
    logic [DIV_W-1:0] r_div_lat [NUM_CH];
    logic [DIV_W-1:0] w_div_eff [NUM_CH];
    logic [NUM_CH-1:0] r_clk_en;
    logic [NUM_CH-1:0] r_clk_div;

    assign w_lock_s    = r_sync[1];
    assign w_lock_lost = (r_low_cnt == GlitchLimit);

    always_ff @(posedge clk_ref_in or posedge reset_in) begin
        if (reset_in) begin
            r_sync    <= 2'b00;
            r_low_cnt <= '0;
        end else begin
            r_sync <= {r_sync[0], pll_lock_in};
            // Saturates at the limit so lock_lost stays asserted while lock remains low.
            if (w_lock_s) begin
                r_low_cnt <= '0;
            end else if (!w_lock_lost) begin
                r_low_cnt <= r_low_cnt + GW'(1);
            end
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_stretch_d = r_stretch;
        case (r_state)
            StWaitLock: begin
                if (w_lock_s) begin
                    w_state_d   = StStretch;
                    w_stretch_d = '0;
                end
            end
            StStretch: begin
                if (w_lock_lost) begin
                    w_state_d = StWaitLock;
                end else if (soft_reset_in) begin
                    w_stretch_d = '0;
                end else if (r_stretch == StretchLast) begin
                    w_state_d = StRun;
                end else begin
                    w_stretch_d = r_stretch + SW'(1);
                end
            end
            StRun: begin
                if (w_lock_lost) begin
                    w_state_d = StWaitLock;
                end else if (soft_reset_in) begin
                    w_state_d   = StStretch;
                    w_stretch_d = '0;
                end
            end
            default: w_state_d = StWaitLock;
        endcase
    end

    always_ff @(posedge clk_ref_in or posedge reset_in) begin
        if (reset_in) begin
            r_state   <= StWaitLock;
            r_stretch <= '0;
            r_reset   <= 1'b1;
            r_resetn  <= 1'b0;
            r_hb      <= '0;
        end else begin
            r_state   <= w_state_d;
            r_stretch <= w_stretch_d;
            r_reset   <= (w_state_d != StRun);
            r_resetn  <= (w_state_d == StRun);
            r_hb      <= r_hb + HbW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_div_eff[i] = (div_in[i*DIV_W +: DIV_W] == '0) ? DIV_W'(1) : div_in[i*DIV_W +: DIV_W];
        end
    end

    // Dividers only count while staying in RUN; any other edge clears them and reloads D.
    assign w_run_hold = (r_state == StRun) && (w_state_d == StRun);

    always_ff @(posedge clk_ref_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_div_cnt[i] <= '0;
                r_div_lat[i] <= DIV_W'(1);
            end
            r_clk_en  <= '0;
            r_clk_div <= '0;
        end else if (!w_run_hold) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_div_cnt[i] <= '0;
                r_div_lat[i] <= w_div_eff[i];
            end
            r_clk_en  <= '0;
            r_clk_div <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_div_cnt[i] == r_div_lat[i] - DIV_W'(1)) begin
                    r_div_cnt[i] <= '0;
                    r_div_lat[i] <= w_div_eff[i];
                    r_clk_en[i]  <= 1'b1;
                    r_clk_div[i] <= ~r_clk_div[i];
                end else begin
                    r_div_cnt[i] <= r_div_cnt[i] + DIV_W'(1);
                    r_clk_en[i]  <= 1'b0;
                end
            end
        end
    end

`ifdef LOCK_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;

    always_ff @(posedge clk_ref_in or posedge reset_in) begin
        if (reset_in) begin
            r_loss_cnt <= 8'd0;
        end else if ((r_state == StRun) && (w_state_d == StWaitLock) && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign lock_loss_cnt_out = r_loss_cnt;
`else
    assign lock_loss_cnt_out = 8'd0;
`endif

    assign reset_out     = r_reset;
    assign resetn_out    = r_resetn;
    assign state_out     = r_state;
    assign clk_en_out    = r_clk_en;
    assign clk_div_out   = r_clk_div;
    assign heartbeat_out = r_hb[HEARTBEAT_BIT];

endmodule
